// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and sequencer for the shared memory port: grants one of two
// requesters, holds the port until mem_ack or timeout, then pulses done/err back.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned TIMEOUT = 15,
   parameter int unsigned CNT_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req,
   input  logic [1:0]        wr,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic [1:0]        gnt,
   output logic [1:0]        done,
   output logic [1:0]        err,
   output logic [DATA_W-1:0] rsp_data,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t              r_state, w_state_n;
   logic                r_prio, w_prio_n;
   logic                r_owner, w_owner_n;
   logic [CNT_W-1:0]    r_cnt, w_cnt_n;
   logic [1:0]          r_gnt, w_gnt_n;
   logic [1:0]          r_done, w_done_n;
   logic [1:0]          r_err, w_err_n;
   logic [DATA_W-1:0]   r_rsp_data, w_rsp_data_n;
   logic                r_mem_en, w_mem_en_n;
   logic                r_mem_wr, w_mem_wr_n;
   logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_n;
   logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_n;

   logic [1:0]          w_elig;
   logic                w_pick;
   logic [1:0]          w_owner_oh;

   // A requester seeing its own done this cycle is not eligible again yet.
   assign w_elig     = req & ~r_done;
   assign w_pick     = (&w_elig) ? r_prio : w_elig[1];
   assign w_owner_oh = r_owner ? 2'b10 : 2'b01;

   // State register and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_prio      <= 1'b0;
         r_owner     <= 1'b0;
         r_cnt       <= '0;
         r_gnt       <= '0;
         r_done      <= '0;
         r_err       <= '0;
         r_rsp_data  <= '0;
         r_mem_en    <= 1'b0;
         r_mem_wr    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_state     <= w_state_n;
         r_prio      <= w_prio_n;
         r_owner     <= w_owner_n;
         r_cnt       <= w_cnt_n;
         r_gnt       <= w_gnt_n;
         r_done      <= w_done_n;
         r_err       <= w_err_n;
         r_rsp_data  <= w_rsp_data_n;
         r_mem_en    <= w_mem_en_n;
         r_mem_wr    <= w_mem_wr_n;
         r_mem_addr  <= w_mem_addr_n;
         r_mem_wdata <= w_mem_wdata_n;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      w_state_n     = r_state;
      w_prio_n      = r_prio;
      w_owner_n     = r_owner;
      w_cnt_n       = r_cnt;
      w_gnt_n       = r_gnt;
      w_done_n      = '0;
      w_err_n       = '0;
      w_rsp_data_n  = r_rsp_data;
      w_mem_en_n    = r_mem_en;
      w_mem_wr_n    = r_mem_wr;
      w_mem_addr_n  = r_mem_addr;
      w_mem_wdata_n = r_mem_wdata;

      case (r_state)
         S_IDLE: begin
            if (|w_elig) begin
               w_state_n     = S_BUSY;
               w_owner_n     = w_pick;
               w_prio_n      = ~w_pick;
               w_cnt_n       = '0;
               w_gnt_n       = w_pick ? 2'b10 : 2'b01;
               w_mem_en_n    = 1'b1;
               w_mem_wr_n    = wr[w_pick];
               w_mem_addr_n  = w_pick ? addr1 : addr0;
               w_mem_wdata_n = w_pick ? wdata1 : wdata0;
            end
         end
         S_BUSY: begin
            // mem_ack takes precedence over the timeout on the final cycle
            if (mem_ack) begin
               w_state_n    = S_IDLE;
               w_done_n     = w_owner_oh;
               w_rsp_data_n = r_mem_wr ? '0 : mem_rdata;
               w_gnt_n      = '0;
               w_mem_en_n   = 1'b0;
               w_mem_wr_n   = 1'b0;
            end else if (r_cnt == CNT_LAST) begin
               w_state_n    = S_IDLE;
               w_done_n     = w_owner_oh;
               w_err_n      = w_owner_oh;
               w_rsp_data_n = '0;
               w_gnt_n      = '0;
               w_mem_en_n   = 1'b0;
               w_mem_wr_n   = 1'b0;
            end else begin
               w_cnt_n = r_cnt + CNT_W'(1);
            end
         end
         default: w_state_n = S_IDLE;
      endcase
   end

   assign gnt       = r_gnt;
   assign done      = r_done;
   assign err       = r_err;
   assign rsp_data  = r_rsp_data;
   assign mem_en    = r_mem_en;
   assign mem_wr    = r_mem_wr;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic,
// all compared cycle by cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

   localparam int unsigned ADDR_W  = 16;
   localparam int unsigned DATA_W  = 16;
   localparam int unsigned TIMEOUT = 15;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [1:0]        req = '0;
   logic [1:0]        wr = '0;
   logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
   logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
   logic [1:0]        gnt, done, err;
   logic [DATA_W-1:0] rsp_data;
   logic              mem_en, mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic              mem_ack = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: owner index (-1 when the port is free), BUSY cycles elapsed, preferred requester
   int                m_owner, m_wait, m_prio;
   logic [1:0]        e_gnt, e_done, e_err;
   logic [DATA_W-1:0] e_rsp;
   logic              e_en, e_wr;
   logic [ADDR_W-1:0] e_addr;
   logic [DATA_W-1:0] e_wdata;

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .req(req), .wr(wr),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt(gnt), .done(done), .err(err), .rsp_data(rsp_data),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1; m_wait = 0; m_prio = 0;
      e_gnt = '0; e_done = '0; e_err = '0; e_rsp = '0;
      e_en = 1'b0; e_wr = 1'b0; e_addr = '0; e_wdata = '0;
   endtask

   task automatic model_finish(input bit timed_out);
      e_done = (m_owner == 1) ? 2'b10 : 2'b01;
      e_err  = timed_out ? e_done : 2'b00;
      e_rsp  = (timed_out || e_wr) ? '0 : mem_rdata;
      e_gnt  = '0; e_en = 1'b0; e_wr = 1'b0;
      m_owner = -1;
   endtask

   // One clock edge of the reference, using the inputs present before the edge
   task automatic model_edge();
      logic [1:0] elig;
      int w;
      elig = req & ~e_done;
      e_done = '0; e_err = '0;
      if (m_owner < 0) begin
         w = -1;
         if (elig == 2'b11) w = m_prio;
         else if (elig[0]) w = 0;
         else if (elig[1]) w = 1;
         if (w >= 0) begin
            m_owner = w; m_wait = 0; m_prio = 1 - w;
            e_gnt   = (w == 1) ? 2'b10 : 2'b01;
            e_en    = 1'b1;
            e_wr    = wr[w];
            e_addr  = (w == 1) ? addr1 : addr0;
            e_wdata = (w == 1) ? wdata1 : wdata0;
         end
      end else begin
         m_wait++;
         if (mem_ack) model_finish(1'b0);
         else if (m_wait == int'(TIMEOUT)) model_finish(1'b1);
      end
   endtask

   task automatic compare_all();
      check("gnt",       32'(gnt),       32'(e_gnt));
      check("done",      32'(done),      32'(e_done));
      check("err",       32'(err),       32'(e_err));
      check("rsp_data",  32'(rsp_data),  32'(e_rsp));
      check("mem_en",    32'(mem_en),    32'(e_en));
      check("mem_wr",    32'(mem_wr),    32'(e_wr));
      check("mem_addr",  32'(mem_addr),  32'(e_addr));
      check("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
   endtask

   task automatic step();
      @(posedge clk);
      if (!rst) model_edge();
      #1;
      compare_all();
   endtask

   task automatic new_operands(input int i);
      wr[i] = 1'($urandom);
      if (i == 0) begin addr0 = ADDR_W'($urandom); wdata0 = DATA_W'($urandom); end
      else        begin addr1 = ADDR_W'($urandom); wdata1 = DATA_W'($urandom); end
   endtask

   initial begin
      int gcnt, en_cnt;
      int unsigned ack_div;
      logic [1:0] order [4];
      logic [ADDR_W-1:0] oaddr [4];

      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      check("reset_gnt", 32'(gnt), 32'h0);
      rst = 1'b0;

      // Read from requester 0, ack two cycles after mem_en
      req = 2'b01; addr0 = 16'h0100; wr = 2'b00;
      gcnt = 0;
      repeat (3) begin step(); if (gnt == 2'b01) gcnt++; end
      mem_ack = 1'b1; mem_rdata = 16'hBEEF;
      step();
      mem_ack = 1'b0;
      check("t1_gnt_cycles", 32'(gcnt), 32'd3);
      check("t1_done", 32'(done), 32'h1);
      check("t1_rsp", 32'(rsp_data), 32'hBEEF);
      check("t1_addr", 32'(mem_addr), 32'h0100);
      req = 2'b00;
      step();

      // Write from requester 1, operands change mid-BUSY
      req = 2'b10; wr = 2'b10; addr1 = 16'h7FFE; wdata1 = 16'h1234;
      step();
      wdata1 = 16'hFFFF;
      step();
      check("wr_wdata_held", 32'(mem_wdata), 32'h1234);
      check("wr_mem_wr", 32'(mem_wr), 32'h1);
      mem_ack = 1'b1; mem_rdata = 16'h5555;
      step();
      mem_ack = 1'b0;
      check("wr_done", 32'(done), 32'h2);
      check("wr_rsp", 32'(rsp_data), 32'h0);
      req = 2'b00; wr = 2'b00;
      step();

      // Timeout with no ack
      req = 2'b01;
      en_cnt = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (mem_en) en_cnt++;
         if (done != 2'b00) break;
      end
      check("to_en_cycles", 32'(en_cnt), TIMEOUT);
      check("to_done", 32'(done), 32'h1);
      check("to_err", 32'(err), 32'h1);
      check("to_rsp", 32'(rsp_data), 32'h0);
      req = 2'b00;
      step();

      // Ack on the final allowed cycle completes normally
      req = 2'b01; mem_rdata = 16'hA5A5;
      step();
      repeat (TIMEOUT - 1) step();
      check("to15_en", 32'(mem_en), 32'h1);
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      check("to15_done", 32'(done), 32'h1);
      check("to15_err", 32'(err), 32'h0);
      check("to15_rsp", 32'(rsp_data), 32'hA5A5);
      req = 2'b00;
      step();

      // Stray ack while idle
      mem_ack = 1'b1;
      repeat (3) step();
      mem_ack = 1'b0;
      check("stray_done", 32'(done), 32'h0);
      check("stray_gnt", 32'(gnt), 32'h0);

      // Reset two cycles into BUSY, then fairness under continuous requests
      req = 2'b10;
      repeat (3) step();
      #2 rst = 1'b1;
      #1;
      check("arst_gnt", 32'(gnt), 32'h0);
      check("arst_en", 32'(mem_en), 32'h0);
      check("arst_addr", 32'(mem_addr), 32'h0);
      model_reset();
      @(posedge clk);
      #1;
      compare_all();
      rst = 1'b0;
      req = 2'b11; addr0 = 16'h1111; addr1 = 16'h2222; wr = 2'b00;
      for (int t = 0; t < 4; t++) begin
         step();
         order[t] = gnt; oaddr[t] = mem_addr;
         step();
         mem_ack = 1'b1;
         step();
         mem_ack = 1'b0;
      end
      for (int t = 0; t < 4; t++) begin
         check("rr_gnt", 32'(order[t]), (t % 2 == 0) ? 32'h1 : 32'h2);
         check("rr_addr", 32'(oaddr[t]), (t % 2 == 0) ? 32'h1111 : 32'h2222);
      end
      req = 2'b00;
      step();

      // Randomized traffic
      ack_div = 4;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if (cyc % 500 == 0) ack_div = $urandom_range(1, 10);
         mem_ack   = ($urandom_range(0, ack_div - 1) == 0);
         mem_rdata = DATA_W'($urandom);
         for (int i = 0; i < 2; i++) begin
            if (!req[i]) begin
               if ($urandom_range(0, 3) == 0) begin req[i] = 1'b1; new_operands(i); end
            end else if (e_done[i]) begin
               if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
               else new_operands(i);
            end else if ($urandom_range(0, 59) == 0) begin
               req[i] = 1'b0;
            end
            if ($urandom_range(0, 9) == 0) new_operands(i);
         end
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
